snake_motion_engine: RTL and testbench

Moves the snake one cell per game tick. Registers the head position, the body position history and the snake length, and drives them into the fruit generator and the collision detector. It takes three upstream events: player direction requests, the fruit generator's food-eaten pulse (growth), and the collision detector's respawn and lives results. It is the stage directly upstream of fruit and collision handling.

---
 rtl/snake_pkg.sv | 33 +++
 rtl/snake_dir_filter.sv | 36 +++
 rtl/snake_motion_engine.sv | 152 +++++++++++++++
 tb/tb_snake_motion_engine.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared constants, direction codes and state encoding for the snake game datapath.
package snake_pkg;

  localparam int COORD_WIDTH    = 10;
  localparam int MAX_LENGTH     = 63;
  localparam int LENGTH_WIDTH   = 6;
  localparam int DISPLAY_WIDTH  = 64;
  localparam int DISPLAY_HEIGHT = 48;

  localparam int INIT_HEAD_X = 32;
  localparam int INIT_HEAD_Y = 24;
  localparam int INIT_LENGTH = 3;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    STEP = 2'b10,
    DEAD = 2'b11
  } state_t;

  // Up/down and left/right differ only in bit 0.
  function automatic dir_t dir_opposite(input dir_t d);
    return dir_t'({d[1], ~d[0]});
  endfunction

endpackage

// File: rtl/snake_dir_filter.sv
// Holds the pending direction, rejects reversals of the committed direction,
// and presents the direction that a commit strobe will make current.
module snake_dir_filter
  import snake_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       accept,
  input  logic       dir_valid,
  input  logic [1:0] dir_in,
  input  logic       multi_cell,
  input  logic       commit,
  output dir_t       dir_out
);

  dir_t pending;
  dir_t committed;
  logic reversal;

  assign reversal = multi_cell && (dir_t'(dir_in) == dir_opposite(committed));
  assign dir_out  = pending;

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      pending   <= DIR_RIGHT;
      committed <= DIR_RIGHT;
    end else begin
      if (accept && dir_valid && !reversal)
        pending <= dir_t'(dir_in);
      if (commit)
        committed <= pending;
    end
  end

endmodule

// File: rtl/snake_motion_engine.sv
// Steps the snake one cell every TICK_DIV cycles, tracking head, body history and length,
// with growth, respawn and death handling.
module snake_motion_engine #(
  parameter int COORD_WIDTH    = snake_pkg::COORD_WIDTH,
  parameter int MAX_LENGTH     = snake_pkg::MAX_LENGTH,
  parameter int LENGTH_WIDTH   = snake_pkg::LENGTH_WIDTH,
  parameter int DISPLAY_WIDTH  = snake_pkg::DISPLAY_WIDTH,
  parameter int DISPLAY_HEIGHT = snake_pkg::DISPLAY_HEIGHT,
  parameter int TICK_DIV       = 4
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic                                  dir_valid,
  input  logic [1:0]                            dir_in,
  input  logic                                  grow,
  input  logic                                  respawn,
  input  logic [COORD_WIDTH-1:0]                respawn_x,
  input  logic [COORD_WIDTH-1:0]                respawn_y,
  input  logic [LENGTH_WIDTH-1:0]               length_in,
  input  logic [2:0]                            lives_in,
  output logic [COORD_WIDTH-1:0]                head_x,
  output logic [COORD_WIDTH-1:0]                head_y,
  output logic [(MAX_LENGTH+1)*COORD_WIDTH-1:0] body_x_flat,
  output logic [(MAX_LENGTH+1)*COORD_WIDTH-1:0] body_y_flat,
  output logic [LENGTH_WIDTH-1:0]               snake_length,
  output logic                                  step_done,
  output logic                                  oob,
  output logic                                  running
);
  import snake_pkg::*;

  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  state_t                   state, state_nxt;
  logic [CNT_W-1:0]         cnt;
  logic [COORD_WIDTH-1:0]   body_x [0:MAX_LENGTH];
  logic [COORD_WIDTH-1:0]   body_y [0:MAX_LENGTH];
  logic [COORD_WIDTH-1:0]   nx, ny;
  logic                     grow_pending;
  logic                     alive, do_init, do_respawn, do_step;
  dir_t                     step_dir;

  assign alive = (lives_in != 3'd0);

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Death outranks respawn, respawn outranks stepping.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        if (!alive)                           state_nxt = DEAD;
        else if (respawn)                     state_nxt = RUN;
        else if (cnt == CNT_W'(TICK_DIV - 2)) state_nxt = STEP;
      end
      STEP: state_nxt = alive ? RUN : DEAD;
      DEAD: if (alive && start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    running    = (state == RUN) || (state == STEP);
    do_init    = ((state == IDLE) && start) || ((state == DEAD) && start && alive);
    do_respawn = running && alive && respawn;
    do_step    = (state == STEP) && alive && !respawn;
  end

  snake_dir_filter u_dir_filter (
    .clk        (clk),
    .reset      (reset),
    .clear      (do_init || do_respawn),
    .accept     (running),
    .dir_valid  (dir_valid),
    .dir_in     (dir_in),
    .multi_cell (snake_length > LENGTH_WIDTH'(1)),
    .commit     (do_step),
    .dir_out    (step_dir)
  );

  always_comb begin
    nx = body_x[0];
    ny = body_y[0];
    case (step_dir)
      DIR_UP:    ny = body_y[0] - COORD_WIDTH'(1);
      DIR_DOWN:  ny = body_y[0] + COORD_WIDTH'(1);
      DIR_LEFT:  nx = body_x[0] - COORD_WIDTH'(1);
      DIR_RIGHT: nx = body_x[0] + COORD_WIDTH'(1);
      default:   nx = body_x[0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset || do_init) begin
      for (int i = 0; i <= MAX_LENGTH; i++) begin
        body_x[i] <= (i < INIT_LENGTH) ? COORD_WIDTH'(INIT_HEAD_X - i) : '0;
        body_y[i] <= (i < INIT_LENGTH) ? COORD_WIDTH'(INIT_HEAD_Y) : '0;
      end
      oob <= 1'b0;
    end else if (do_respawn) begin
      for (int i = 0; i <= MAX_LENGTH; i++) begin
        body_x[i] <= respawn_x;
        body_y[i] <= respawn_y;
      end
      oob <= (respawn_x >= COORD_WIDTH'(DISPLAY_WIDTH)) || (respawn_y >= COORD_WIDTH'(DISPLAY_HEIGHT));
    end else if (do_step) begin
      for (int i = 1; i <= MAX_LENGTH; i++) begin
        body_x[i] <= body_x[i-1];
        body_y[i] <= body_y[i-1];
      end
      body_x[0] <= nx;
      body_y[0] <= ny;
      oob <= (nx >= COORD_WIDTH'(DISPLAY_WIDTH)) || (ny >= COORD_WIDTH'(DISPLAY_HEIGHT));
    end
  end

  always_ff @(posedge clk) begin
    if (!reset || do_init) begin
      snake_length <= LENGTH_WIDTH'(INIT_LENGTH);
      grow_pending <= 1'b0;
      step_done    <= 1'b0;
      cnt          <= '0;
    end else begin
      step_done <= do_step;
      cnt       <= ((state == RUN) && (state_nxt == RUN) && !do_respawn) ? cnt + CNT_W'(1) : '0;
      if (do_respawn) begin
        snake_length <= (length_in == '0) ? LENGTH_WIDTH'(1) : length_in;
        grow_pending <= 1'b0;
      end else if (do_step) begin
        if ((grow_pending || grow) && (snake_length != LENGTH_WIDTH'(MAX_LENGTH)))
          snake_length <= snake_length + LENGTH_WIDTH'(1);
        grow_pending <= 1'b0;
      end else if (running && grow) begin
        grow_pending <= 1'b1;
      end
    end
  end

  assign head_x = body_x[0];
  assign head_y = body_y[0];

  for (genvar g = 0; g <= MAX_LENGTH; g++) begin : g_flat
    assign body_x_flat[g*COORD_WIDTH +: COORD_WIDTH] = body_x[g];
    assign body_y_flat[g*COORD_WIDTH +: COORD_WIDTH] = body_y[g];
  end

endmodule

// File: tb/tb_snake_motion_engine.sv
// Directed bench for snake_motion_engine with hand-computed expected positions and lengths.
module tb_snake_motion_engine;

  localparam int CW = 10;
  localparam int ML = 63;
  localparam int LW = 6;

  logic              clk = 1'b0;
  logic              reset, start, dir_valid, grow, respawn;
  logic [1:0]        dir_in;
  logic [CW-1:0]     respawn_x, respawn_y;
  logic [LW-1:0]     length_in;
  logic [2:0]        lives_in;
  logic [CW-1:0]     head_x, head_y;
  logic [(ML+1)*CW-1:0] body_x_flat, body_y_flat;
  logic [LW-1:0]     snake_length;
  logic              step_done, oob, running;

  int checks = 0;
  int failures = 0;
  int n;
  int cnt;

  snake_motion_engine #(.TICK_DIV(4)) dut (
    .clk(clk), .reset(reset), .start(start), .dir_valid(dir_valid), .dir_in(dir_in),
    .grow(grow), .respawn(respawn), .respawn_x(respawn_x), .respawn_y(respawn_y),
    .length_in(length_in), .lives_in(lives_in), .head_x(head_x), .head_y(head_y),
    .body_x_flat(body_x_flat), .body_y_flat(body_y_flat), .snake_length(snake_length),
    .step_done(step_done), .oob(oob), .running(running)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic logic [CW-1:0] bx(input int i);
    return body_x_flat[i*CW +: CW];
  endfunction

  function automatic logic [CW-1:0] by(input int i);
    return body_y_flat[i*CW +: CW];
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_step(output int k);
    k = 0;
    do begin
      cyc();
      k++;
    end while (!step_done && k < 20);
    check("step_seen", {31'd0, step_done}, 32'd1);
  endtask

  task automatic req_dir(input logic [1:0] d);
    dir_valid = 1'b1;
    dir_in    = d;
    cyc();
    dir_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; dir_valid = 1'b0; dir_in = 2'b00; grow = 1'b0;
    respawn = 1'b0; respawn_x = '0; respawn_y = '0; length_in = '0; lives_in = 3'd3;
    cyc(); cyc();
    reset = 1'b1;
    cyc();
    check("rst_head_x", head_x, 32);
    check("rst_head_y", head_y, 24);
    check("rst_body1_x", bx(1), 31);
    check("rst_body2_x", bx(2), 30);
    check("rst_body3_x", bx(3), 0);
    check("rst_len", snake_length, 3);
    check("rst_running", running, 0);
    check("rst_oob", oob, 0);
    check("rst_step_done", step_done, 0);

    // start and three plain steps to the right
    start = 1'b1; cyc(); start = 1'b0;
    check("start_running", running, 1);
    wait_step(n); check("step1_lat", n, 4); check("step1_x", head_x, 33); check("step1_y", head_y, 24);
    wait_step(n); check("step2_lat", n, 4); check("step2_x", head_x, 34);
    wait_step(n); check("step3_lat", n, 4); check("step3_x", head_x, 35);
    check("step3_b1x", bx(1), 34); check("step3_b1y", by(1), 24); check("step3_b2x", bx(2), 33);
    cyc(); check("pulse_width", step_done, 0);

    // direction handling
    req_dir(2'b10);
    wait_step(n); check("rev_ignored_x", head_x, 36); check("rev_ignored_y", head_y, 24);
    req_dir(2'b00); req_dir(2'b11);
    wait_step(n); check("last_wins_x", head_x, 37); check("last_wins_y", head_y, 24);
    req_dir(2'b00);
    wait_step(n); check("up_y", head_y, 23); check("up_x", head_x, 37);
    req_dir(2'b01);
    wait_step(n); check("down_rev_y", head_y, 22);
    req_dir(2'b11);
    wait_step(n); check("right_x", head_x, 38); check("right_y", head_y, 22);

    // growth: two pulses in one period count once
    grow = 1'b1; cyc(); grow = 1'b0; cyc(); grow = 1'b1; cyc(); grow = 1'b0;
    wait_step(n); check("grow_len", snake_length, 4); check("grow_x", head_x, 39);
    wait_step(n); check("grow_once", snake_length, 4);
    grow = 1'b1;
    for (int i = 0; i < 65; i++) wait_step(n);
    check("grow_sat", snake_length, 63);
    check("sat_head_x", head_x, 105);
    check("sat_oob", oob, 1);
    grow = 1'b0;

    // respawn at x=0 then step left across the edge
    respawn = 1'b1; respawn_x = 10'd0; respawn_y = 10'd5; length_in = 6'd1; cyc(); respawn = 1'b0;
    check("rsp0_x", head_x, 0); check("rsp0_y", head_y, 5); check("rsp0_len", snake_length, 1);
    check("rsp0_oob", oob, 0); check("rsp0_done", step_done, 0);
    req_dir(2'b10);
    wait_step(n); check("wrap_x", head_x, 1023); check("wrap_y", head_y, 5); check("wrap_oob", oob, 1);

    // respawn in the STEP cycle suppresses the step
    cyc(); cyc(); cyc();
    respawn = 1'b1; respawn_x = 10'd20; respawn_y = 10'd20; length_in = 6'd0; cyc(); respawn = 1'b0;
    check("rspS_done", step_done, 0); check("rspS_x", head_x, 20); check("rspS_y", head_y, 20);
    check("rspS_len", snake_length, 1); check("rspS_oob", oob, 0);
    cnt = 0;
    for (int i = 0; i <= ML; i++) if (bx(i) != 10'd20 || by(i) != 10'd20) cnt++;
    check("rspS_body_bad", cnt, 0);
    wait_step(n); check("rspS_lat", n, 4); check("rspS_next_x", head_x, 21); check("rspS_b1x", bx(1), 20);

    // death, inputs ignored while dead, restart
    lives_in = 3'd0; cyc();
    check("dead_running", running, 0);
    respawn = 1'b1; respawn_x = 10'd5; respawn_y = 10'd5; grow = 1'b1; dir_valid = 1'b1; dir_in = 2'b00;
    cyc();
    respawn = 1'b0; grow = 1'b0; dir_valid = 1'b0;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin cyc(); if (step_done) cnt++; end
    check("dead_no_steps", cnt, 0);
    check("dead_x", head_x, 21); check("dead_y", head_y, 20); check("dead_len", snake_length, 1);
    lives_in = 3'd3; start = 1'b1; cyc(); start = 1'b0;
    check("restart_x", head_x, 32); check("restart_y", head_y, 24); check("restart_len", snake_length, 3);
    check("restart_b1x", bx(1), 31); check("restart_b3x", bx(3), 0); check("restart_running", running, 1);
    wait_step(n); check("restart_lat", n, 4); check("restart_step_x", head_x, 33); check("restart_step_y", head_y, 24);
    check("restart_len_after", snake_length, 3);

    // reset landing on the STEP cycle
    cyc(); cyc(); cyc();
    reset = 1'b0; cyc(); reset = 1'b1;
    check("midrst_done", step_done, 0); check("midrst_x", head_x, 32); check("midrst_running", running, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
